flash_timing_engine: RTL and testbench
======================================

FLASH_TIMING_ENGINE -- requirements
Module: flash_timing_engine

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, chip bus width; legal values 8 or 16.
REQ-002 The block SHALL have parameter SETUP_CYCLES, default 1, cycles of CS/CLE/ALE setup before the strobe; minimum 1.
REQ-003 The block SHALL have parameter STROBE_CYCLES, default 2, cycles WE_N/RE_N is held low; minimum 1.
REQ-004 The block SHALL have parameter HOLD_CYCLES, default 1, cycles after the strobe rises; minimum 1.
REQ-005 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, limit for a ready wait; minimum 2.
REQ-006 The block SHALL have these ports:
- i_master_clk  in  1  sole clock; all logic on the rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_chip_data  in  DATA_WIDTH  chip bus read data.
- o_chip_data  out  DATA_WIDTH  chip bus write data.
- o_chip_data_out  out  1  bus drive enable.
- o_chip_cs_n, o_chip_ale, o_chip_cle, o_chip_we_n, o_chip_re_n  out  1 each  chip controls.
- i_chip_ready  in  1  chip R/B#, asynchronous to the clock.
- i_op_request  in  1  operation request.
- i_op_type  in  3  operation code: 0 CMD, 1 ADDR, 2 WRITE, 3 READ, 4 WAIT_READY.
- i_op_data  in  DATA_WIDTH  command, address or write word.
- i_op_count  in  8  read burst length; 0 is treated as 1.
- o_op_ready  out  1  engine idle and able to accept.
- o_op_done  out  1  one-cycle completion pulse.
- o_timeout  out  1  one-cycle pulse, coincident with o_op_done, when a ready wait expires.
- o_rd_data  out  DATA_WIDTH  read word.
- o_rd_data_valid  out  1  one-cycle pulse qualifying o_rd_data.

Function
REQ-007 Operations SHALL be accepted only when i_op_request and o_op_ready are both high on the same edge; type, data and count SHALL be latched at that edge; requests made while busy SHALL be ignored.
REQ-008 The FSM states SHALL be IDLE, SETUP, STROBE, HOLD, WAIT_RDY and DONE, with a phase counter loaded on each state entry.
REQ-009 o_op_ready SHALL be high only in IDLE; DONE SHALL last one cycle and then return to IDLE.
REQ-010 All chip outputs SHALL be registered from the next-state decode, so pin levels change on the same edge as the state register.
REQ-011 CMD, ADDR, WRITE and READ SHALL sequence through SETUP (SETUP_CYCLES), STROBE (STROBE_CYCLES), HOLD (HOLD_CYCLES) and then DONE.
REQ-012 o_chip_cs_n SHALL be low throughout SETUP, STROBE and HOLD, and high in every other state.
REQ-013 o_chip_cle SHALL be high for CMD and o_chip_ale high for ADDR, each across SETUP through HOLD.
REQ-014 During STROBE, o_chip_we_n SHALL be low for CMD, ADDR and WRITE, and o_chip_re_n SHALL be low for READ; both SHALL be high otherwise.
REQ-015 o_chip_data_out SHALL be high during SETUP through HOLD of CMD, ADDR and WRITE, and low otherwise.
REQ-016 o_chip_data SHALL hold the latched word during those cycles; for CMD and ADDR only bits [7:0] SHALL be driven, with upper bits 0.
REQ-017 For READ, i_chip_data SHALL be captured on the edge leaving STROBE, with o_rd_data_valid pulsed high in the following cycle.
REQ-018 A READ burst of N words SHALL be one SETUP, then N STROBE/HOLD pairs, returning from HOLD to STROBE while words remain, so that exactly N valid pulses occur.
REQ-019 WAIT_READY SHALL keep o_chip_cs_n high and all strobes inactive, and SHALL sample i_chip_ready through a two-flop synchroniser.
REQ-020 WAIT_READY SHALL go to DONE on the first synchronised high, or after TIMEOUT_CYCLES cycles in WAIT_RDY with o_timeout pulsed together with o_op_done.
REQ-021 Op types 5-7 SHALL go directly to DONE with no bus activity.
REQ-022 Latency from accept to o_op_done SHALL be SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES+1 for single-word ops, and SETUP_CYCLES+N*(STROBE_CYCLES+HOLD_CYCLES)+1 for a READ burst.

Reset
REQ-023 Asserting i_reset_n low, at any time including mid-operation, SHALL immediately force the following:
- state IDLE;
- o_chip_cs_n=1, o_chip_we_n=1, o_chip_re_n=1;
- o_chip_ale=0, o_chip_cle=0, o_chip_data_out=0, o_chip_data=0;
- o_op_done=0, o_timeout=0, o_rd_data_valid=0, o_rd_data=0;
- o_op_ready=0 while reset is held, and 1 on the first edge after release;
- synchroniser and counters cleared.

Verification (default parameters)
REQ-024 CMD 0x70 -> cs_n low 4 cycles, cle high 4 cycles, we_n low in cycles 2-3, data 0x0070 driven, o_op_done on cycle 5.
REQ-025 READ with count 3 and chip data 0x1111/0x2222/0x3333 -> three valid pulses in order, re_n low 2 cycles each, o_op_done 11 cycles after accept.
REQ-026 WAIT_READY with i_chip_ready rising 20 cycles after accept -> o_op_done within 23 cycles and o_timeout=0; with ready held low -> o_op_done with o_timeout=1 after 1000 cycles.
REQ-027 i_reset_n pulsed low during the STROBE of a WRITE -> we_n=1, cs_n=1 and data_out=0 before the next edge, no o_op_done, and a new CMD accepted after release.
REQ-028 A back-to-back ADDR requested on the DONE cycle -> ignored; the same request held into IDLE -> accepted; i_op_type 6 -> o_op_done 1 cycle later with cs_n held high.

Source files
------------

// File: rtl/flash_timing_engine_if.sv
// Operation handshake bundle between a host sequencer and the flash timing engine.
// The host side drives requests; the engine side answers with ready/done/read data.
interface flash_timing_engine_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  i_op_request;
  logic [2:0]            i_op_type;
  logic [DATA_WIDTH-1:0] i_op_data;
  logic [7:0]            i_op_count;
  logic                  o_op_ready;
  logic                  o_op_done;
  logic                  o_timeout;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_data_valid;

  modport master (
    output i_op_request, i_op_type, i_op_data, i_op_count,
    input  o_op_ready, o_op_done, o_timeout, o_rd_data, o_rd_data_valid
  );

  modport slave (
    input  i_op_request, i_op_type, i_op_data, i_op_count,
    output o_op_ready, o_op_done, o_timeout, o_rd_data, o_rd_data_valid
  );

endinterface

// File: rtl/flash_timing_engine.sv
// Raw NAND bus timing engine: turns single CMD/ADDR/WRITE/READ/WAIT_READY
// operations into setup/strobe/hold pin sequences. Every chip pin is a flop
// fed from the next-state decode so pins move on the same edge as the state.
module flash_timing_engine #(
  parameter int DATA_WIDTH     = 16,
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 2,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  i_master_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_chip_data,
  output logic [DATA_WIDTH-1:0] o_chip_data,
  output logic                  o_chip_data_out,
  output logic                  o_chip_cs_n,
  output logic                  o_chip_ale,
  output logic                  o_chip_cle,
  output logic                  o_chip_we_n,
  output logic                  o_chip_re_n,
  input  logic                  i_chip_ready,
  flash_timing_engine_if.slave  op_bus
);

  localparam logic [2:0] OP_CMD   = 3'd0;
  localparam logic [2:0] OP_ADDR  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_WAIT  = 3'd4;

  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(8'hFF);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    WAIT_RDY,
    DONE
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [31:0]           phase_cnt;
  logic [31:0]           phase_load;
  logic [2:0]            op_type;
  logic [DATA_WIDTH-1:0] op_data;
  logic [7:0]            words_left;
  logic                  ready_meta;
  logic                  ready_sync;

  logic                  op_ready_q;
  logic                  op_done_q;
  logic                  timeout_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  accept;
  logic [2:0]            cur_type;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  bus_phase;
  logic                  drive_type;
  logic                  rd_capture;
  logic                  cs_n_d;
  logic                  cle_d;
  logic                  ale_d;
  logic                  we_n_d;
  logic                  re_n_d;
  logic                  data_out_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  timeout_d;

  // ready is only ever high in IDLE, so accept implies the engine is idle;
  // on the accept edge the latched op is not yet valid, so use the live inputs
  assign accept   = op_bus.i_op_request & op_ready_q;
  assign cur_type = accept ? op_bus.i_op_type : op_type;
  assign cur_data = accept ? op_bus.i_op_data : op_data;

  // Next-state decode; a READ burst loops HOLD back to STROBE while words remain
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op_bus.i_op_type)
            OP_CMD, OP_ADDR, OP_WRITE, OP_READ: next_state = SETUP;
            OP_WAIT:                            next_state = WAIT_RDY;
            default:                            next_state = DONE;
          endcase
        end
      end
      SETUP:    if (phase_cnt == 32'd0) next_state = STROBE;
      STROBE:   if (phase_cnt == 32'd0) next_state = HOLD;
      HOLD: begin
        if (phase_cnt == 32'd0) begin
          next_state = (op_type == OP_READ && words_left != 8'd0) ? STROBE : DONE;
        end
      end
      WAIT_RDY: if (ready_sync || phase_cnt == 32'd0) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Pin levels and pulses for the state being entered on the coming edge
  always_comb begin
    phase_load = 32'd0;
    case (next_state)
      SETUP:    phase_load = 32'(SETUP_CYCLES - 1);
      STROBE:   phase_load = 32'(STROBE_CYCLES - 1);
      HOLD:     phase_load = 32'(HOLD_CYCLES - 1);
      WAIT_RDY: phase_load = 32'(TIMEOUT_CYCLES - 1);
      default:  phase_load = 32'd0;
    endcase

    bus_phase  = (next_state == SETUP) || (next_state == STROBE) || (next_state == HOLD);
    drive_type = (cur_type == OP_CMD) || (cur_type == OP_ADDR) || (cur_type == OP_WRITE);
    cs_n_d     = !bus_phase;
    cle_d      = bus_phase && (cur_type == OP_CMD);
    ale_d      = bus_phase && (cur_type == OP_ADDR);
    we_n_d     = !((next_state == STROBE) && drive_type);
    re_n_d     = !((next_state == STROBE) && (cur_type == OP_READ));
    data_out_d = bus_phase && drive_type;
    data_d     = '0;
    if (data_out_d) begin
      data_d = ((cur_type == OP_CMD) || (cur_type == OP_ADDR)) ? (cur_data & BYTE_MASK) : cur_data;
    end
    rd_capture = (state == STROBE) && (next_state == HOLD) && (op_type == OP_READ);
    timeout_d  = (state == WAIT_RDY) && (next_state == DONE) && !ready_sync;
  end

  // State register with a phase counter reloaded on every state entry
  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      phase_cnt <= 32'd0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        phase_cnt <= phase_load;
      end else if (phase_cnt != 32'd0) begin
        phase_cnt <= phase_cnt - 32'd1;
      end
    end
  end

  // Latch the operation on accept and count burst words as each is captured
  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      op_type    <= OP_CMD;
      op_data    <= '0;
      words_left <= 8'd0;
    end else if (accept) begin
      op_type    <= op_bus.i_op_type;
      op_data    <= op_bus.i_op_data;
      words_left <= (op_bus.i_op_count == 8'd0) ? 8'd1 : op_bus.i_op_count;
    end else if (rd_capture) begin
      words_left <= words_left - 8'd1;
    end
  end

  // Two-flop synchroniser for the chip's asynchronous R/B# line
  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ready_meta <= 1'b0;
      ready_sync <= 1'b0;
    end else begin
      ready_meta <= i_chip_ready;
      ready_sync <= ready_meta;
    end
  end

  // Registered chip pins and host-side status
  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_chip_cs_n     <= 1'b1;
      o_chip_cle      <= 1'b0;
      o_chip_ale      <= 1'b0;
      o_chip_we_n     <= 1'b1;
      o_chip_re_n     <= 1'b1;
      o_chip_data_out <= 1'b0;
      o_chip_data     <= '0;
      op_ready_q      <= 1'b0;
      op_done_q       <= 1'b0;
      timeout_q       <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_data_q       <= '0;
    end else begin
      o_chip_cs_n     <= cs_n_d;
      o_chip_cle      <= cle_d;
      o_chip_ale      <= ale_d;
      o_chip_we_n     <= we_n_d;
      o_chip_re_n     <= re_n_d;
      o_chip_data_out <= data_out_d;
      o_chip_data     <= data_d;
      op_ready_q      <= (next_state == IDLE);
      op_done_q       <= (next_state == DONE);
      timeout_q       <= timeout_d;
      rd_valid_q      <= rd_capture;
      if (rd_capture) begin
        rd_data_q <= i_chip_data;
      end
    end
  end

  assign op_bus.o_op_ready      = op_ready_q;
  assign op_bus.o_op_done       = op_done_q;
  assign op_bus.o_timeout       = timeout_q;
  assign op_bus.o_rd_data       = rd_data_q;
  assign op_bus.o_rd_data_valid = rd_valid_q;

endmodule

// File: tb/tb_flash_timing_engine.sv
// Directed bench for flash_timing_engine: a scoreboard holds the expected
// completion cycle/timeout of each operation and each expected read word.
module tb_flash_timing_engine;

  logic        clk;
  logic        reset_n;
  logic [15:0] chip_data_in;
  logic [15:0] chip_data;
  logic        chip_data_out;
  logic        chip_cs_n;
  logic        chip_ale;
  logic        chip_cle;
  logic        chip_we_n;
  logic        chip_re_n;
  logic        chip_ready;

  int assert_count = 0;
  int fail_count   = 0;
  int cycle        = 0;

  typedef struct {
    int   cyc;
    logic to;
  } done_exp_t;

  done_exp_t   exp_done_q[$];
  logic [15:0] exp_rd_q[$];
  logic [15:0] chip_q[$];

  flash_timing_engine_if #(.DATA_WIDTH(16)) op_bus ();

  flash_timing_engine dut (
    .i_master_clk    (clk),
    .i_reset_n       (reset_n),
    .i_chip_data     (chip_data_in),
    .o_chip_data     (chip_data),
    .o_chip_data_out (chip_data_out),
    .o_chip_cs_n     (chip_cs_n),
    .o_chip_ale      (chip_ale),
    .o_chip_cle      (chip_cle),
    .o_chip_we_n     (chip_we_n),
    .o_chip_re_n     (chip_re_n),
    .i_chip_ready    (chip_ready),
    .op_bus          (op_bus)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time completions
  always @(posedge clk) cycle <= cycle + 1;

  // Chip read model: presents the next queued word on each falling RE_N
  always @(negedge chip_re_n) begin
    if (chip_q.size() > 0) chip_data_in = chip_q.pop_front();
  end

  // Runaway guard
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired assertions=%0d failures=%0d", assert_count, fail_count);
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives a request just after an edge and returns the cycle it was accepted in
  task automatic apply_stimulus(input logic [2:0] op_type, input logic [15:0] op_data,
                                input logic [7:0] op_count, output int acc);
    int waited;
    @(posedge clk);
    #1;
    op_bus.i_op_type    = op_type;
    op_bus.i_op_data    = op_data;
    op_bus.i_op_count   = op_count;
    op_bus.i_op_request = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!op_bus.o_op_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_output("accept_ready", 32'(op_bus.o_op_ready), 32'd1);
    acc = cycle;
    @(posedge clk);
    #1;
    op_bus.i_op_request = 1'b0;
  endtask

  // Scoreboard: pops expectations whenever the DUT signals completion or data
  always @(negedge clk) begin
    if (reset_n) begin
      if (op_bus.o_op_done) begin
        if (exp_done_q.size() == 0) begin
          check_output("unexpected_done", 32'(op_bus.o_op_done), 32'd0);
        end else begin
          done_exp_t e;
          e = exp_done_q.pop_front();
          check_output("done_cycle", 32'(cycle), 32'(e.cyc));
          check_output("done_timeout", 32'(op_bus.o_timeout), 32'(e.to));
        end
      end else if (op_bus.o_timeout) begin
        check_output("timeout_without_done", 32'(op_bus.o_timeout), 32'd0);
      end
      if (op_bus.o_rd_data_valid) begin
        if (exp_rd_q.size() == 0) begin
          check_output("unexpected_rd_valid", 32'(op_bus.o_rd_data_valid), 32'd0);
        end else begin
          check_output("rd_data", 32'(op_bus.o_rd_data), 32'(exp_rd_q.pop_front()));
        end
      end
    end
  end

  // Directed sequence
  initial begin
    int acc;
    int acc2;
    int re_low;
    int we_low;
    int cs_low;
    logic in_bus;

    reset_n             = 1'b0;
    chip_ready          = 1'b0;
    chip_data_in        = 16'h0000;
    op_bus.i_op_request = 1'b0;
    op_bus.i_op_type    = 3'd0;
    op_bus.i_op_data    = 16'h0000;
    op_bus.i_op_count   = 8'd0;

    // Reset values while reset is held
    #12;
    check_output("rst_cs_n", 32'(chip_cs_n), 32'd1);
    check_output("rst_we_n", 32'(chip_we_n), 32'd1);
    check_output("rst_re_n", 32'(chip_re_n), 32'd1);
    check_output("rst_ale", 32'(chip_ale), 32'd0);
    check_output("rst_cle", 32'(chip_cle), 32'd0);
    check_output("rst_data_out", 32'(chip_data_out), 32'd0);
    check_output("rst_data", 32'(chip_data), 32'd0);
    check_output("rst_done", 32'(op_bus.o_op_done), 32'd0);
    check_output("rst_timeout", 32'(op_bus.o_timeout), 32'd0);
    check_output("rst_rd_valid", 32'(op_bus.o_rd_data_valid), 32'd0);
    check_output("rst_rd_data", 32'(op_bus.o_rd_data), 32'd0);
    check_output("rst_ready", 32'(op_bus.o_op_ready), 32'd0);
    #10;
    reset_n = 1'b1;
    @(negedge clk);
    check_output("ready_after_release", 32'(op_bus.o_op_ready), 32'd1);

    // CMD 0x70 with junk in the upper byte, which must not reach the bus
    $display("[TB] CMD 0x70");
    apply_stimulus(3'd0, 16'hFF70, 8'd0, acc);
    exp_done_q.push_back('{acc + 5, 1'b0});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      in_bus = (k >= 1 && k <= 4);
      check_output($sformatf("cmd_cs_n_c%0d", k), 32'(chip_cs_n), 32'(!in_bus));
      check_output($sformatf("cmd_cle_c%0d", k), 32'(chip_cle), 32'(in_bus));
      check_output($sformatf("cmd_we_n_c%0d", k), 32'(chip_we_n), 32'(!(k == 2 || k == 3)));
      check_output($sformatf("cmd_data_out_c%0d", k), 32'(chip_data_out), 32'(in_bus));
      check_output($sformatf("cmd_data_c%0d", k), 32'(chip_data), in_bus ? 32'h0070 : 32'h0);
    end

    // ADDR, then a second ADDR requested in the DONE cycle and held into IDLE
    $display("[TB] ADDR back-to-back");
    apply_stimulus(3'd1, 16'h1234, 8'd0, acc);
    exp_done_q.push_back('{acc + 5, 1'b0});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_output($sformatf("addr_ale_c%0d", k), 32'(chip_ale), 32'd1);
      check_output($sformatf("addr_cle_c%0d", k), 32'(chip_cle), 32'd0);
      check_output($sformatf("addr_data_c%0d", k), 32'(chip_data), 32'h0034);
    end
    @(posedge clk);
    #1;
    op_bus.i_op_type    = 3'd1;
    op_bus.i_op_data    = 16'h0056;
    op_bus.i_op_request = 1'b1;
    @(negedge clk);
    check_output("b2b_ready_in_done", 32'(op_bus.o_op_ready), 32'd0);
    @(negedge clk);
    check_output("b2b_ready_in_idle", 32'(op_bus.o_op_ready), 32'd1);
    acc2 = cycle;
    exp_done_q.push_back('{acc2 + 5, 1'b0});
    @(posedge clk);
    #1;
    op_bus.i_op_request = 1'b0;
    @(negedge clk);
    check_output("b2b_data", 32'(chip_data), 32'h0056);
    check_output("b2b_ale", 32'(chip_ale), 32'd1);
    repeat (6) @(posedge clk);

    // WRITE interrupted by reset during STROBE
    $display("[TB] WRITE with reset in strobe");
    apply_stimulus(3'd2, 16'hBEEF, 8'd0, acc);
    @(negedge clk);
    check_output("wr_data", 32'(chip_data), 32'hBEEF);
    check_output("wr_data_out", 32'(chip_data_out), 32'd1);
    @(negedge clk);
    check_output("wr_we_n_strobe", 32'(chip_we_n), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("rst_mid_we_n", 32'(chip_we_n), 32'd1);
    check_output("rst_mid_cs_n", 32'(chip_cs_n), 32'd1);
    check_output("rst_mid_data_out", 32'(chip_data_out), 32'd0);
    check_output("rst_mid_data", 32'(chip_data), 32'd0);
    check_output("rst_mid_ready", 32'(op_bus.o_op_ready), 32'd0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    check_output("rst_mid_ready_after", 32'(op_bus.o_op_ready), 32'd1);
    apply_stimulus(3'd0, 16'h0090, 8'd0, acc);
    exp_done_q.push_back('{acc + 5, 1'b0});
    repeat (7) @(posedge clk);

    // READ burst of three words
    $display("[TB] READ burst x3");
    chip_q.push_back(16'h1111);
    chip_q.push_back(16'h2222);
    chip_q.push_back(16'h3333);
    exp_rd_q.push_back(16'h1111);
    exp_rd_q.push_back(16'h2222);
    exp_rd_q.push_back(16'h3333);
    apply_stimulus(3'd3, 16'h0000, 8'd3, acc);
    exp_done_q.push_back('{acc + 11, 1'b0});
    re_low = 0;
    we_low = 0;
    cs_low = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (!chip_re_n) re_low++;
      if (!chip_we_n) we_low++;
      if (!chip_cs_n) cs_low++;
    end
    check_output("rd_re_low_cycles", 32'(re_low), 32'd6);
    check_output("rd_we_low_cycles", 32'(we_low), 32'd0);
    check_output("rd_cs_low_cycles", 32'(cs_low), 32'd10);

    // READ with count 0 behaves as a single word
    $display("[TB] READ count 0");
    chip_q.push_back(16'h5A5A);
    exp_rd_q.push_back(16'h5A5A);
    apply_stimulus(3'd3, 16'h0000, 8'd0, acc);
    exp_done_q.push_back('{acc + 5, 1'b0});
    repeat (7) @(posedge clk);

    // WAIT_READY with the chip going ready 20 cycles after accept
    $display("[TB] WAIT_READY ready");
    apply_stimulus(3'd4, 16'h0000, 8'd0, acc);
    exp_done_q.push_back('{acc + 23, 1'b0});
    @(negedge clk);
    check_output("wait_cs_n", 32'(chip_cs_n), 32'd1);
    check_output("wait_we_n", 32'(chip_we_n), 32'd1);
    check_output("wait_re_n", 32'(chip_re_n), 32'd1);
    repeat (19) @(posedge clk);
    #1;
    chip_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chip_ready = 1'b0;
    repeat (4) @(posedge clk);

    // Reserved op type goes straight to DONE
    $display("[TB] op type 6");
    apply_stimulus(3'd6, 16'h00AA, 8'd0, acc);
    exp_done_q.push_back('{acc + 1, 1'b0});
    @(negedge clk);
    check_output("type6_cs_n_c1", 32'(chip_cs_n), 32'd1);
    check_output("type6_data_out_c1", 32'(chip_data_out), 32'd0);
    @(negedge clk);
    check_output("type6_cs_n_c2", 32'(chip_cs_n), 32'd1);

    // WAIT_READY with the chip never ready
    $display("[TB] WAIT_READY timeout");
    apply_stimulus(3'd4, 16'h0000, 8'd0, acc);
    exp_done_q.push_back('{acc + 1001, 1'b1});
    repeat (1005) @(posedge clk);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
    check_output("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
